// File: rtl/cook_sequencer.sv
// Microwave cooking sequencer.
// Samples the active-low front-panel buttons, runs the IDLE/READY/COOK/PAUSE/DONE
// state machine, owns the seconds countdown with its one-second prescaler, and
// decodes the magnetron enable and cook-finished flag straight from the state.
module cook_sequencer #(
  parameter int TICK_DIV = 10,
  parameter int TIME_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startn,
  input  logic              stopn,
  input  logic              clearn,
  input  logic              door_closed,
  input  logic              load_en,
  input  logic [TIME_W-1:0] load_secs,
  output logic [TIME_W-1:0] secs_left,
  output logic              mag_on,
  output logic              timer_done,
  output logic [2:0]        state
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            cur_state;
  state_t            next_state;
  logic [TIME_W-1:0] secs_next;
  logic [PRE_W-1:0]  pre_cnt;
  logic [PRE_W-1:0]  pre_next;

  // Current and previous button samples; 1 means released.
  logic start_s, start_d;
  logic stop_s,  stop_d;
  logic clear_s, clear_d;

  logic start_press;
  logic stop_press;
  logic clear_press;
  logic tick;

  // Sample each button once per clock and keep the previous sample for edge detection.
  // NOTE: every register here uses non-blocking assignment so all flops update
  // from the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_s <= 1'b1;
      start_d <= 1'b1;
      stop_s  <= 1'b1;
      stop_d  <= 1'b1;
      clear_s <= 1'b1;
      clear_d <= 1'b1;
    end else begin
      start_s <= startn;
      start_d <= start_s;
      stop_s  <= stopn;
      stop_d  <= stop_s;
      clear_s <= clearn;
      clear_d <= clear_s;
    end
  end

  // A press is a released-to-pressed transition, so a held button fires only once.
  assign start_press = start_d & ~start_s;
  assign stop_press  = stop_d  & ~stop_s;
  assign clear_press = clear_d & ~clear_s;

  // One-second strobe; the prescaler only ever runs in COOK.
  assign tick = (cur_state == COOK) && (pre_cnt == PRE_W'(TICK_DIV - 1));

  // State, countdown and prescaler registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
      secs_left <= '0;
      pre_cnt   <= '0;
    end else begin
      cur_state <= next_state;
      secs_left <= secs_next;
      pre_cnt   <= pre_next;
    end
  end

  // Next-state, next-count and prescaler logic with clear > door > stop > start > load priority.
  // NOTE: every output of this block gets a default first, so no path can leave a
  // value unassigned and infer a latch.
  always_comb begin
    next_state = cur_state;
    secs_next  = secs_left;
    pre_next   = '0;

    case (cur_state)
      IDLE: begin
        if (clear_press) begin
          secs_next = '0;
        end else if (load_en && (load_secs != '0)) begin
          next_state = READY;
          secs_next  = load_secs;
        end
      end

      READY: begin
        if (clear_press) begin
          next_state = IDLE;
          secs_next  = '0;
        end else if (start_press && door_closed && !stop_press) begin
          next_state = COOK;
        end else if (load_en) begin
          if (load_secs == '0) begin
            next_state = IDLE;
            secs_next  = '0;
          end else begin
            secs_next = load_secs;
          end
        end
      end

      COOK: begin
        if (clear_press) begin
          next_state = IDLE;
          secs_next  = '0;
        end else if (!door_closed || stop_press) begin
          // Countdown is held; the prescaler drops back to 0 while paused.
          next_state = PAUSE;
        end else if (tick) begin
          if (secs_left <= TIME_W'(1)) begin
            next_state = DONE;
            secs_next  = '0;
          end else begin
            secs_next = secs_left - TIME_W'(1);
          end
        end else begin
          pre_next = pre_cnt + PRE_W'(1);
        end
      end

      PAUSE: begin
        if (clear_press || stop_press) begin
          next_state = IDLE;
          secs_next  = '0;
        end else if (start_press && door_closed) begin
          // Resume with a fresh second; any partial second is discarded.
          next_state = COOK;
        end
      end

      DONE: begin
        if (clear_press || stop_press || !door_closed) begin
          next_state = IDLE;
          secs_next  = '0;
        end
      end

      default: begin
        next_state = IDLE;
        secs_next  = '0;
      end
    endcase
  end

  assign state      = cur_state;
  assign mag_on     = (cur_state == COOK);
  assign timer_done = (cur_state == DONE);

endmodule

// File: tb/tb_cook_sequencer.sv
// Self-checking bench for cook_sequencer.
// Expected snapshots (state, seconds left) are queued as stimulus is applied and
// compared against the outputs on the falling clock edge; mag_on and timer_done
// expectations follow from the expected state.
module tb_cook_sequencer;

  localparam int TIME_W = 12;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic              clk;
  logic              reset;
  logic              startn;
  logic              stopn;
  logic              clearn;
  logic              door_closed;
  logic              load_en;
  logic [TIME_W-1:0] load_secs;
  logic [TIME_W-1:0] secs_left;
  logic              mag_on;
  logic              timer_done;
  logic [2:0]        state;

  cook_sequencer #(
    .TICK_DIV(10),
    .TIME_W  (TIME_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .door_closed(door_closed),
    .load_en    (load_en),
    .load_secs  (load_secs),
    .secs_left  (secs_left),
    .mag_on     (mag_on),
    .timer_done (timer_done),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] st;
    int         secs;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Counts rising edges of mag_on, i.e. entries into COOK.
  logic mag_q = 1'b0;
  int   cook_entries = 0;
  always @(negedge clk) begin
    if (mag_on && !mag_q) cook_entries <= cook_entries + 1;
    mag_q <= mag_on;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic expect_snap(input string tag, input logic [2:0] st, input int secs);
    exp_t e;
    e.tag  = tag;
    e.st   = st;
    e.secs = secs;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the current outputs.
  task automatic observe();
    exp_t e;
    check("sb_pending", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, "_state"}, 32'(state), 32'(e.st));
      check({e.tag, "_secs"}, 32'(secs_left), 32'(e.secs));
      check({e.tag, "_mag"}, 32'(mag_on), 32'(e.st == S_COOK));
      check({e.tag, "_done"}, 32'(timer_done), 32'(e.st == S_DONE));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int secs);
    load_secs = TIME_W'(secs);
    load_en   = 1'b1;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // which: 0 = start, 1 = stop, 2 = clear. Returns after the state has reacted.
  task automatic press(input int which);
    if (which == 0) startn = 1'b0;
    if (which == 1) stopn  = 1'b0;
    if (which == 2) clearn = 1'b0;
    @(negedge clk);
    startn = 1'b1;
    stopn  = 1'b1;
    clearn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int base;
    reset       = 1'b1;
    startn      = 1'b1;
    stopn       = 1'b1;
    clearn      = 1'b1;
    door_closed = 1'b1;
    load_en     = 1'b0;
    load_secs   = '0;
    cycles(2);
    expect_snap("reset", S_IDLE, 0);
    observe();
    reset = 1'b0;
    cycles(2);

    // 1: full 3 s cook with start latency and tick spacing.
    load(3);
    expect_snap("t1_ready", S_READY, 3); observe();
    startn = 1'b0;
    @(negedge clk);
    expect_snap("t1_one_edge", S_READY, 3); observe();
    startn = 1'b1;
    @(negedge clk);
    expect_snap("t1_cook", S_COOK, 3); observe();
    cycles(9);
    expect_snap("t1_pre_tick", S_COOK, 3); observe();
    cycles(1);
    expect_snap("t1_sec2", S_COOK, 2); observe();
    cycles(10);
    expect_snap("t1_sec1", S_COOK, 1); observe();
    cycles(9);
    expect_snap("t1_last", S_COOK, 1); observe();
    cycles(1);
    expect_snap("t1_done", S_DONE, 0); observe();
    cycles(3);
    expect_snap("t1_done_hold", S_DONE, 0); observe();
    press(2);
    expect_snap("t1_clear", S_IDLE, 0); observe();

    // 2: door opened mid-cook, then resumed.
    load(3);
    press(0);
    cycles(10);
    expect_snap("t2_sec2", S_COOK, 2); observe();
    door_closed = 1'b0;
    @(negedge clk);
    expect_snap("t2_pause", S_PAUSE, 2); observe();
    press(0);
    expect_snap("t2_start_open", S_PAUSE, 2); observe();
    door_closed = 1'b1;
    press(0);
    expect_snap("t2_resume", S_COOK, 2); observe();
    cycles(19);
    expect_snap("t2_sec1", S_COOK, 1); observe();
    cycles(1);
    expect_snap("t2_done", S_DONE, 0); observe();
    door_closed = 1'b0;
    @(negedge clk);
    expect_snap("t2_door_idle", S_IDLE, 0); observe();
    door_closed = 1'b1;

    // 3: clear and start on the same edge in READY.
    load(4);
    startn = 1'b0;
    clearn = 1'b0;
    @(negedge clk);
    startn = 1'b1;
    clearn = 1'b1;
    expect_snap("t3_mid", S_READY, 4); observe();
    @(negedge clk);
    expect_snap("t3_idle", S_IDLE, 0); observe();
    cycles(2);
    expect_snap("t3_stay", S_IDLE, 0); observe();

    // 4: held start gives a single press; stop pauses, second stop cancels.
    load(9);
    base   = cook_entries;
    startn = 1'b0;
    cycles(50);
    expect_snap("t4_held", S_COOK, 5); observe();
    check("t4_cook_entries", 32'(cook_entries - base), 1);
    startn = 1'b1;
    press(1);
    expect_snap("t4_pause", S_PAUSE, 5); observe();
    cycles(3);
    expect_snap("t4_pause_hold", S_PAUSE, 5); observe();
    press(1);
    expect_snap("t4_cancel", S_IDLE, 0); observe();

    // 5: ignored loads and start with the door open.
    load(0);
    expect_snap("t5_load0", S_IDLE, 0); observe();
    load(6);
    load(7);
    expect_snap("t5_reload", S_READY, 7); observe();
    load(0);
    expect_snap("t5_reload0", S_IDLE, 0); observe();
    load(3);
    press(0);
    load(5);
    expect_snap("t5_load_cook", S_COOK, 3); observe();
    press(2);
    expect_snap("t5_clear_cook", S_IDLE, 0); observe();
    load(3);
    door_closed = 1'b0;
    press(0);
    cycles(2);
    expect_snap("t5_door_open", S_READY, 3); observe();
    door_closed = 1'b1;
    press(2);
    expect_snap("t5_clear", S_IDLE, 0); observe();

    // 6: asynchronous reset between edges while cooking.
    load(3);
    press(0);
    cycles(5);
    expect_snap("t6_cook", S_COOK, 3); observe();
    #2;
    reset = 1'b1;
    #1;
    expect_snap("t6_async", S_IDLE, 0); observe();
    @(negedge clk);
    reset = 1'b0;
    cycles(2);
    expect_snap("t6_after", S_IDLE, 0); observe();

    check("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
